// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage access unit: size codes, FSM encoding
// and store-data lane replication.
package mem_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ADDR = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_DONE      = 3'd3,
    ST_DRAIN     = 3'd4
  } mem_state_e;

  function automatic logic [31:0] fmt_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] res;
    case (size)
      MEM_SIZE_BYTE: res = {4{wdata[7:0]}};
      MEM_SIZE_HALF: res = {2{wdata[15:0]}};
      default:       res = wdata;
    endcase
    return res;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic res;
    case (size)
      MEM_SIZE_BYTE: res = 1'b0;
      MEM_SIZE_HALF: res = addr_lo[0];
      default:       res = (addr_lo != 2'b00);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data lane select plus sign/zero extension (purely combinational).
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed lane and extend it to 32 bits.
  always_comb begin
    case (addr)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    if (addr[1]) begin
      half_v = rdata[31:16];
    end else begin
      half_v = rdata[15:0];
    end
    case (size)
      MEM_SIZE_BYTE: result = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      MEM_SIZE_HALF: result = {{16{~is_unsigned & half_v[15]}}, half_v};
      default:       result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store controller driving a req/addr_ok/data_ok split bus.
// Optional macro UNALIGNED_EXC_EN: misaligned half/word accesses raise adelM/adesM.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_enM,
  input  logic        mem_wenM,
  input  logic [1:0]  mem_sizeM,
  input  logic        mem_unsignedM,
  input  logic [31:0] mem_addrM,
  input  logic [31:0] mem_wdataM,
  input  logic        flushM,
  input  logic        stall_extM,
  output logic        stall_memM,
  output logic [31:0] mem_rdataM,
  output logic        adelM,
  output logic        adesM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  mem_state_e  state_r;
  logic [31:0] hold_r;
  logic        flush_seen_r;
  logic        wr_r;
  logic        uns_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        valid;
  logic        issue;
  logic [31:0] ext_data;
  logic [31:0] load_data;

`ifdef UNALIGNED_EXC_EN
  logic bad_align;
  assign bad_align = mem_enM & ~flushM & misaligned(mem_sizeM, mem_addrM[1:0]);
  assign adelM     = bad_align & ~mem_wenM;
  assign adesM     = bad_align & mem_wenM;
  assign valid     = mem_enM & ~flushM & ~bad_align;
`else
  assign adelM = 1'b0;
  assign adesM = 1'b0;
  assign valid = mem_enM & ~flushM;
`endif

  assign issue = (state_r == ST_IDLE) & valid;

  // Extraction uses the fields captured at issue so a flush cannot disturb it.
  mem_load_ext u_ext (
    .rdata       (data_rdata),
    .addr        (addr_r[1:0]),
    .size        (size_r),
    .is_unsigned (uns_r),
    .result      (ext_data)
  );

  assign load_data = wr_r ? 32'd0 : ext_data;

  // Bus fields, stall request and returned load data.
  always_comb begin
    if (state_r == ST_WAIT_ADDR) begin
      data_req   = 1'b1;
      data_wr    = wr_r;
      data_size  = size_r;
      data_addr  = addr_r;
      data_wdata = wdata_r;
    end else begin
      data_req   = issue;
      data_wr    = mem_wenM;
      data_size  = mem_sizeM;
      data_addr  = mem_addrM;
      data_wdata = fmt_wdata(mem_sizeM, mem_wdataM);
    end
    case (state_r)
      ST_IDLE:      stall_memM = valid;
      ST_WAIT_ADDR: stall_memM = 1'b1;
      ST_WAIT_DATA: stall_memM = ~data_data_ok;
      ST_DRAIN:     stall_memM = mem_enM & ~flushM;
      default:      stall_memM = 1'b0;
    endcase
    case (state_r)
      ST_WAIT_DATA: mem_rdataM = data_data_ok ? load_data : 32'd0;
      ST_DONE:      mem_rdataM = hold_r;
      default:      mem_rdataM = 32'd0;
    endcase
  end

  // Access FSM, request capture and load-data hold register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      hold_r       <= 32'd0;
      flush_seen_r <= 1'b0;
      wr_r         <= 1'b0;
      uns_r        <= 1'b0;
      size_r       <= 2'd0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (issue) begin
            wr_r         <= mem_wenM;
            uns_r        <= mem_unsignedM;
            size_r       <= mem_sizeM;
            addr_r       <= mem_addrM;
            wdata_r      <= fmt_wdata(mem_sizeM, mem_wdataM);
            flush_seen_r <= 1'b0;
            state_r      <= data_addr_ok ? ST_WAIT_DATA : ST_WAIT_ADDR;
          end
        end
        ST_WAIT_ADDR: begin
          if (data_addr_ok) begin
            state_r <= (flush_seen_r | flushM) ? ST_DRAIN : ST_WAIT_DATA;
          end else begin
            flush_seen_r <= flush_seen_r | flushM;
          end
        end
        ST_WAIT_DATA: begin
          if (data_data_ok) begin
            if (stall_extM & ~flushM) begin
              hold_r  <= load_data;
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_IDLE;
            end
          end else if (flushM) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          if (~stall_extM | flushM) begin
            state_r <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (data_data_ok) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (honours UNALIGNED_EXC_EN).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_enM, mem_wenM, mem_unsignedM, flushM, stall_extM;
  logic [1:0]  mem_sizeM;
  logic [31:0] mem_addrM, mem_wdataM;
  logic        stall_memM, adelM, adesM;
  logic [31:0] mem_rdataM;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .mem_enM(mem_enM), .mem_wenM(mem_wenM), .mem_sizeM(mem_sizeM),
    .mem_unsignedM(mem_unsignedM), .mem_addrM(mem_addrM), .mem_wdataM(mem_wdataM),
    .flushM(flushM), .stall_extM(stall_extM),
    .stall_memM(stall_memM), .mem_rdataM(mem_rdataM), .adelM(adelM), .adesM(adesM),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_enM = 1'b0; mem_wenM = 1'b0; mem_sizeM = 2'd0; mem_unsignedM = 1'b0;
    mem_addrM = 32'd0; mem_wdataM = 32'd0; flushM = 1'b0; stall_extM = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
  endtask

  // Two-cycle load: addr_ok in cycle 0, data_ok in cycle 1.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] rd, input logic [31:0] exp);
    @(negedge clk);
    mem_enM = 1'b1; mem_wenM = 1'b0; mem_sizeM = sz; mem_unsignedM = uns;
    mem_addrM = a; data_addr_ok = 1'b1; data_data_ok = 1'b0;
    #1;
    check_eq({tag, "_c0_req"}, 32'(data_req), 32'd1);
    check_eq({tag, "_c0_stall"}, 32'(stall_memM), 32'd1);
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rd;
    #1;
    check_eq({tag, "_c1_rdata"}, mem_rdataM, exp);
    check_eq({tag, "_c1_stall"}, 32'(stall_memM), 32'd0);
    check_eq({tag, "_c1_req"}, 32'(data_req), 32'd0);
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_stall", 32'(stall_memM), 32'd0);
    check_eq("rst_rdata", mem_rdataM, 32'd0);
    check_eq("rst_req", 32'(data_req), 32'd0);
    check_eq("rst_adel", 32'(adelM), 32'd0);
    rst = 1'b1;

    // LB and extension table
    do_load("lb_1003", 32'h0000_1003, 2'd0, 1'b0, 32'h80FF_FF00, 32'hFFFF_FF80);
    do_load("lh_6002", 32'h0000_6002, 2'd1, 1'b0, 32'h8001_7FFF, 32'hFFFF_8001);
    do_load("lhu_6000", 32'h0000_6000, 2'd1, 1'b1, 32'h8001_7FFF, 32'h0000_7FFF);
    do_load("lbu_6000", 32'h0000_6000, 2'd0, 1'b1, 32'h8001_7FFF, 32'h0000_00FF);
    do_load("lb_6001", 32'h0000_6001, 2'd0, 1'b0, 32'h8001_7FFF, 32'h0000_007F);

    // SH with addr_ok delayed three cycles
    @(negedge clk);
    mem_enM = 1'b1; mem_wenM = 1'b1; mem_sizeM = 2'd1;
    mem_addrM = 32'h0000_2002; mem_wdataM = 32'h1234_ABCD;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("sh_wait%0d_req", i), 32'(data_req), 32'd1);
      check_eq($sformatf("sh_wait%0d_stall", i), 32'(stall_memM), 32'd1);
      check_eq($sformatf("sh_wait%0d_addr", i), data_addr, 32'h0000_2002);
      check_eq($sformatf("sh_wait%0d_wdata", i), data_wdata, 32'hABCD_ABCD);
      check_eq($sformatf("sh_wait%0d_wr", i), 32'(data_wr), 32'd1);
      @(negedge clk);
    end
    data_addr_ok = 1'b1;
    #1;
    check_eq("sh_aok_req", 32'(data_req), 32'd1);
    @(negedge clk);
    data_addr_ok = 1'b0;
    #1;
    check_eq("sh_wdata_stall", 32'(stall_memM), 32'd1);
    check_eq("sh_wdata_req", 32'(data_req), 32'd0);
    @(negedge clk);
    data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
    #1;
    check_eq("sh_dok_stall", 32'(stall_memM), 32'd0);
    check_eq("sh_dok_rdata", mem_rdataM, 32'd0);
    @(negedge clk);
    idle_inputs();

    // LW completes while stall_extM holds M for two cycles
    @(negedge clk);
    mem_enM = 1'b1; mem_sizeM = 2'd2; mem_addrM = 32'h0000_3000; data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; stall_extM = 1'b1;
    #1;
    check_eq("lw_ext_c1_rdata", mem_rdataM, 32'hDEAD_BEEF);
    check_eq("lw_ext_c1_stall", 32'(stall_memM), 32'd0);
    @(negedge clk);
    data_data_ok = 1'b0; data_rdata = 32'd0;
    #1;
    check_eq("lw_done_c2_rdata", mem_rdataM, 32'hDEAD_BEEF);
    check_eq("lw_done_c2_req", 32'(data_req), 32'd0);
    check_eq("lw_done_c2_stall", 32'(stall_memM), 32'd0);
    @(negedge clk);
    stall_extM = 1'b0;
    #1;
    check_eq("lw_done_c3_rdata", mem_rdataM, 32'hDEAD_BEEF);
    @(negedge clk);
    mem_enM = 1'b0;
    #1;
    check_eq("lw_idle_rdata", mem_rdataM, 32'd0);
    @(negedge clk);
    idle_inputs();

    // LHU flushed in WAIT_DATA, LW behind it waits for the drain
    @(negedge clk);
    mem_enM = 1'b1; mem_sizeM = 2'd1; mem_unsignedM = 1'b1;
    mem_addrM = 32'h0000_4002; data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0; flushM = 1'b1;
    #1;
    check_eq("flush_wd_stall", 32'(stall_memM), 32'd1);
    @(negedge clk);
    flushM = 1'b0; mem_sizeM = 2'd2; mem_unsignedM = 1'b0; mem_addrM = 32'h0000_5000;
    #1;
    check_eq("drain_req", 32'(data_req), 32'd0);
    check_eq("drain_stall", 32'(stall_memM), 32'd1);
    @(negedge clk);
    data_data_ok = 1'b1; data_rdata = 32'h1111_2222;
    #1;
    check_eq("drain_dok_req", 32'(data_req), 32'd0);
    check_eq("drain_dok_stall", 32'(stall_memM), 32'd1);
    check_eq("drain_dok_rdata", mem_rdataM, 32'd0);
    @(negedge clk);
    data_data_ok = 1'b0; data_addr_ok = 1'b1;
    #1;
    check_eq("lw2_req", 32'(data_req), 32'd1);
    check_eq("lw2_addr", data_addr, 32'h0000_5000);
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    #1;
    check_eq("lw2_rdata", mem_rdataM, 32'hCAFE_F00D);
    check_eq("lw2_stall", 32'(stall_memM), 32'd0);
    @(negedge clk);
    idle_inputs();

    // Misaligned LW
`ifdef UNALIGNED_EXC_EN
    @(negedge clk);
    mem_enM = 1'b1; mem_sizeM = 2'd2; mem_addrM = 32'h0000_1001;
    #1;
    check_eq("unal_adel", 32'(adelM), 32'd1);
    check_eq("unal_req", 32'(data_req), 32'd0);
    check_eq("unal_stall", 32'(stall_memM), 32'd0);
    @(negedge clk);
    idle_inputs();
`else
    do_load("unal_lw", 32'h0000_1001, 2'd2, 1'b0, 32'h1234_5678, 32'h1234_5678);
    @(negedge clk);
    mem_enM = 1'b1; mem_sizeM = 2'd2; mem_addrM = 32'h0000_1001;
    #1;
    check_eq("unal_adel", 32'(adelM), 32'd0);
    check_eq("unal_addr", data_addr, 32'h0000_1001);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    @(negedge clk);
    idle_inputs();
`endif

    // Reset while in WAIT_ADDR
    @(negedge clk);
    mem_enM = 1'b1; mem_sizeM = 2'd2; mem_addrM = 32'h0000_7000;
    @(negedge clk);
    #1;
    check_eq("rstwa_pre_req", 32'(data_req), 32'd1);
    rst = 1'b0; mem_enM = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rstwa_req", 32'(data_req), 32'd0);
    check_eq("rstwa_stall", 32'(stall_memM), 32'd0);
    check_eq("rstwa_rdata", mem_rdataM, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
